// File: rtl/risc_spm_boot_loader_pkg.sv
// risc_spm_boot_loader_pkg: loader state encoding and default configuration
package risc_spm_boot_loader_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, HALTED, TIMEOUT} state_e;
    localparam int WORD_SIZE      = 8;
    localparam int ADDR_SIZE      = 8;
    localparam int MEM_DEPTH      = 256;
    localparam int CLEAR_EN       = 1;
    localparam int TIMEOUT_CYCLES = 2800;
    localparam int CNT_SIZE       = 16;
endpackage

// File: rtl/risc_spm_boot_loader_if.sv
// risc_spm_boot_loader_if: image beat handshake in, SRAM write port out
interface risc_spm_boot_loader_if #(
    parameter int word_size = 8,
    parameter int addr_size = 8
);
    logic                 img_valid;
    logic                 img_ready;
    logic                 img_last;
    logic [addr_size-1:0] img_addr;
    logic [word_size-1:0] img_data;
    logic                 mem_wr;
    logic [addr_size-1:0] mem_addr;
    logic [word_size-1:0] mem_data;
    modport master (output img_valid, img_addr, img_data, img_last, input img_ready, mem_wr, mem_addr, mem_data);
    modport slave (input img_valid, img_addr, img_data, img_last, output img_ready, mem_wr, mem_addr, mem_data);
endinterface

// File: rtl/risc_spm_boot_loader.sv
// risc_spm_boot_loader: clears SRAM, streams a boot image into it, then runs the core until HALT or timeout
module risc_spm_boot_loader
    import risc_spm_boot_loader_pkg::*;
#(
    parameter int word_size      = WORD_SIZE,
    parameter int addr_size      = ADDR_SIZE,
    parameter int mem_depth      = MEM_DEPTH,
    parameter int clear_en       = CLEAR_EN,
    parameter int timeout_cycles = TIMEOUT_CYCLES,
    parameter int cnt_size       = CNT_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    risc_spm_boot_loader_if.slave bus,
    input  logic                  halt_i,
    output logic                  cpu_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic                  addr_err_o,
    output logic [cnt_size-1:0]   run_cycles_o
);
    localparam logic [cnt_size-1:0]  CNT_MAX   = '1;
    localparam logic [addr_size:0]   DEPTH     = (addr_size+1)'(mem_depth);
    localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(mem_depth - 1);
    state_e               state_q;
    logic                 mem_wr_q, img_ready_q, cpu_rst_q, busy_q, done_q, timeout_q, addr_err_q;
    logic [addr_size-1:0] mem_addr_q;
    logic [word_size-1:0] mem_data_q;
    logic [cnt_size-1:0]  run_q, run_d;
    logic                 accept, in_range, tmo_hit;
    always_comb begin
        run_d    = (run_q == CNT_MAX) ? run_q : run_q + cnt_size'(1);
        accept   = bus.img_valid && img_ready_q;
        in_range = {1'b0, bus.img_addr} < DEPTH;
        tmo_hit  = (timeout_cycles != 0) && (32'(run_d) == 32'(timeout_cycles));
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            img_ready_q <= 1'b0;
            cpu_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            run_q       <= '0;
        end else begin
            mem_wr_q <= 1'b0;
            unique case (state_q)
                IDLE, HALTED, TIMEOUT: if (start_i) begin
                    state_q     <= (clear_en != 0) ? CLEAR : LOAD;
                    mem_wr_q    <= clear_en != 0;
                    mem_addr_q  <= '0;
                    mem_data_q  <= '0;
                    img_ready_q <= clear_en == 0;
                    cpu_rst_q   <= 1'b0;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                    timeout_q   <= 1'b0;
                    addr_err_q  <= 1'b0;
                    run_q       <= '0;
                end
                CLEAR: begin
                    mem_wr_q    <= mem_addr_q != LAST_ADDR;
                    mem_addr_q  <= (mem_addr_q == LAST_ADDR) ? mem_addr_q : mem_addr_q + addr_size'(1);
                    img_ready_q <= mem_addr_q == LAST_ADDR;
                    state_q     <= (mem_addr_q == LAST_ADDR) ? LOAD : CLEAR;
                end
                LOAD: if (accept) begin
                    mem_wr_q   <= in_range;
                    addr_err_q <= addr_err_q || !in_range;
                    if (in_range) begin
                        mem_addr_q <= bus.img_addr;
                        mem_data_q <= bus.img_data;
                    end
                    if (bus.img_last) begin
                        state_q     <= RUN;
                        img_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    // halt outranks a coincident timeout; a halted core keeps its reset released
                    run_q     <= run_d;
                    cpu_rst_q <= halt_i || !tmo_hit;
                    if (halt_i || tmo_hit) begin
                        state_q   <= halt_i ? HALTED : TIMEOUT;
                        busy_q    <= 1'b0;
                        done_q    <= halt_i;
                        timeout_q <= !halt_i;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.img_ready = img_ready_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign cpu_rst_o     = cpu_rst_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign addr_err_o    = addr_err_q;
    assign run_cycles_o  = run_q;
endmodule
